rca_pr_scheduler: RTL and testbench
===================================

// Module: rca_pr_scheduler
// PURPOSE
//  Queues partial-reconfiguration (PR) requests for RCA grid slots and issues them one at a
//  time to the PR controller. A request starts only while rca_config_locked is low, so no
//  slot is rewritten while RCA use instructions are in flight. Drives pr_requests_incomplete,
//  which the grid, LSQ and rca_unit use to hold off IO-unit output.
// PARAMETERS
//  NUM_GRID_SLOTS      8     reconfigurable grid slots
//  BITSTREAM_ID_W      6     bitstream identifier width
//  PR_QUEUE_DEPTH      4     request FIFO entries; power of 2, >=2
//  PR_TIMEOUT_CYCLES   4096  watchdog limit in BUSY (used only with RCA_PR_TIMEOUT_EN)
// PORTS
//  clk                  in   1    clock
//  rst                  in   1    asynchronous, active-high reset
//  pr_req_valid         in   1    request offered
//  pr_req_ready         out  1    FIFO can accept (= !full)
//  pr_req_slot          in   SW   target slot, SW=$clog2(NUM_GRID_SLOTS)
//  pr_req_bitstream     in   BW   bitstream id, BW=BITSTREAM_ID_W
//  rca_config_locked    in   1    RCA FIFOs populated; start of a new PR is blocked
//  pr_start             out  1    start request to the PR controller
//  pr_start_ready       in   1    PR controller accepts the start
//  pr_slot              out  SW   slot being issued or reconfigured
//  pr_bitstream         out  BW   bitstream being issued or reconfigured
//  pr_done              in   1    one-cycle pulse: current reconfiguration finished
//  pr_requests_incomplete out 1   any PR queued or active
//  pr_slot_busy         out  NUM_GRID_SLOTS  one-hot of the slot in ISSUE or BUSY
//  pr_error             out  1    sticky timeout flag
//  pr_error_clr         in   1    clears pr_error
// BEHAVIOUR
//  - Reset values: FIFO empty; state=IDLE; pr_start=0; pr_slot=0; pr_bitstream=0;
//    pr_slot_busy=0; pr_error=0; pr_req_ready=1; pr_requests_incomplete=0.
//  - Push: pr_req_valid && pr_req_ready. While full, pr_req_ready=0 and the push is dropped,
//    even if a pop happens in the same cycle. Simultaneous push and pop when not full: both
//    take effect and the count is unchanged. Pointers wrap modulo PR_QUEUE_DEPTH.
//  - Requests issue strictly in FIFO order. A duplicate request for the same slot is not merged.
//  - FSM:
//    IDLE  -> ISSUE when the FIFO is not empty && !rca_config_locked (registered decision).
//             A push into an empty FIFO gives pr_start no earlier than 2 cycles after the push.
//    ISSUE -> pr_start=1. pr_slot and pr_bitstream show the FIFO head and stay stable until
//             accepted. If pr_start_ready=1, pop the head, latch the head into pr_slot and
//             pr_bitstream, and go to BUSY. Lock is ignored once in ISSUE. pr_done in ISSUE
//             is ignored.
//    BUSY  -> pr_start=0. pr_done=1 -> IDLE. pr_slot and pr_bitstream hold until the next
//             issue.
//  - pr_slot_busy = (state != IDLE) ? (1 << pr_slot) : 0.
//  - pr_requests_incomplete = !empty || (state != IDLE). This is combinational from
//    registered state, so it is high in the same cycle as the cycle after the push edge.
//  - pr_error_clr takes priority over a same-cycle set of pr_error.
//  - rst asserted mid-operation: all state is cleared asynchronously and queued requests are
//    discarded. The PR controller is reset by the same rst.
// CONFIGURATION
//  RCA_PR_TIMEOUT_EN defined: a 32-bit counter clears on entry to BUSY and increments each
//    BUSY cycle. When count == PR_TIMEOUT_CYCLES-1 and pr_done=0: set pr_error and go to
//    IDLE (abort). pr_done in that same cycle counts as success and does not set the error.
//  RCA_PR_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely; pr_error tied 0 and
//    pr_error_clr is ignored.
// STRUCTURE
//  - taiga_types package: rca_pr_req_t {slot, bitstream}; pr_sched_state_t enum
//    {PR_IDLE, PR_ISSUE, PR_BUSY}; NUM_GRID_SLOTS; BITSTREAM_ID_W.
//  - One sub-module, pr_req_fifo: parameterised FIFO of rca_pr_req_t with push, pop, full,
//    empty and head outputs. The FSM lives in the top level.
// TESTING
//  1 Push {slot3,bs5} while unlocked, with pr_start_ready=1 -> pr_start high 2 cycles later
//    with slot3/bs5; pr_slot_busy=8'h08; pr_done -> IDLE, pr_requests_incomplete=0.
//  2 rca_config_locked=1, push 2 requests -> no pr_start and incomplete=1. Drop the lock ->
//    the two requests issue in order; a lock raised during BUSY does not abort.
//  3 Push 5 requests back-to-back with no issue (DEPTH=4) -> ready=0 after the 4th; the 5th is
//    dropped; exactly 4 pr_start handshakes follow.
//  4 Hold pr_start_ready=0 for 10 cycles -> pr_start stays 1, slot/bitstream stable, no pop.
//  5 With RCA_PR_TIMEOUT_EN and PR_TIMEOUT_CYCLES=16, no pr_done -> pr_error=1 after 16 BUSY
//    cycles and state=IDLE; pr_error_clr -> 0. Without the macro -> BUSY holds and pr_error=0.
//  6 Assert rst during BUSY with 3 requests queued -> all outputs return to reset values;
//    incomplete=0.

Source files
------------

// File: rtl/rca_pr_scheduler_pkg.sv
// Shared types for the RCA partial-reconfiguration scheduler.
// Holds grid geometry, the queued request record and the scheduler state encoding.
package taiga_types;

    localparam int unsigned NUM_GRID_SLOTS = 8;
    localparam int unsigned BITSTREAM_ID_W = 6;
    localparam int unsigned SLOT_W         = $clog2(NUM_GRID_SLOTS);

    typedef struct packed {
        logic [SLOT_W-1:0]         slot;
        logic [BITSTREAM_ID_W-1:0] bitstream;
    } rca_pr_req_t;

    typedef enum logic [1:0] {
        PR_IDLE,
        PR_ISSUE,
        PR_BUSY
    } pr_sched_state_t;

    // One-hot mask for a grid slot index.
    function automatic logic [NUM_GRID_SLOTS-1:0] slot_onehot(input logic [SLOT_W-1:0] slot);
        return NUM_GRID_SLOTS'(1) << slot;
    endfunction

endpackage

// File: rtl/rca_pr_scheduler_pr_req_fifo.sv
// Request FIFO for the PR scheduler.
// Pushes while full are dropped even when a pop happens in the same cycle; DEPTH must be a power of 2.
module pr_req_fifo
    import taiga_types::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  rca_pr_req_t push_data,
    input  logic        pop,
    output rca_pr_req_t head,
    output logic        full,
    output logic        empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    rca_pr_req_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at the power-of-2 depth; count tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rca_pr_scheduler.sv
// PR request scheduler: queues slot reconfiguration requests and issues them one at a time,
// starting a new one only while the RCA configuration is unlocked.
// Optional watchdog on the BUSY phase is enabled by defining RCA_PR_TIMEOUT_EN.
module rca_pr_scheduler
    import taiga_types::*;
#(
    parameter int unsigned PR_QUEUE_DEPTH    = 4,
    parameter int unsigned PR_TIMEOUT_CYCLES = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pr_req_valid,
    output logic                      pr_req_ready,
    input  logic [SLOT_W-1:0]         pr_req_slot,
    input  logic [BITSTREAM_ID_W-1:0] pr_req_bitstream,
    input  logic                      rca_config_locked,
    output logic                      pr_start,
    input  logic                      pr_start_ready,
    output logic [SLOT_W-1:0]         pr_slot,
    output logic [BITSTREAM_ID_W-1:0] pr_bitstream,
    input  logic                      pr_done,
    output logic                      pr_requests_incomplete,
    output logic [NUM_GRID_SLOTS-1:0] pr_slot_busy,
    output logic                      pr_error,
    input  logic                      pr_error_clr
);

    pr_sched_state_t           state;
    pr_sched_state_t           state_next;
    rca_pr_req_t               push_data;
    rca_pr_req_t               head;
    logic                      full;
    logic                      empty;
    logic                      pop;
    logic [SLOT_W-1:0]         slot_q;
    logic [BITSTREAM_ID_W-1:0] bitstream_q;

`ifdef RCA_PR_TIMEOUT_EN
    logic [31:0] busy_cnt;
    logic        timeout_hit;
`else
    localparam int unsigned unused_timeout_cycles = PR_TIMEOUT_CYCLES;
    logic unused_error_clr;
    assign unused_error_clr = pr_error_clr;
    assign pr_error         = 1'b0;
`endif

    assign push_data.slot      = pr_req_slot;
    assign push_data.bitstream = pr_req_bitstream;

    pr_req_fifo #(
        .DEPTH(PR_QUEUE_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (pr_req_valid),
        .push_data(push_data),
        .pop      (pop),
        .head     (head),
        .full     (full),
        .empty    (empty)
    );

    // During ISSUE the head is shown directly; otherwise the last issued request is held.
    assign pr_slot                = (state == PR_ISSUE) ? head.slot : slot_q;
    assign pr_bitstream           = (state == PR_ISSUE) ? head.bitstream : bitstream_q;
    assign pr_slot_busy           = (state != PR_IDLE) ? slot_onehot(pr_slot) : '0;
    assign pr_req_ready           = !full;
    assign pr_requests_incomplete = !empty || (state != PR_IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= PR_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode, issue handshake and BUSY completion/abort.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        pr_start   = 1'b0;
`ifdef RCA_PR_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        case (state)
            PR_IDLE: begin
                if (!empty && !rca_config_locked) begin
                    state_next = PR_ISSUE;
                end
            end
            PR_ISSUE: begin
                pr_start = 1'b1;
                if (pr_start_ready) begin
                    pop        = 1'b1;
                    state_next = PR_BUSY;
                end
            end
            PR_BUSY: begin
                if (pr_done) begin
                    state_next = PR_IDLE;
`ifdef RCA_PR_TIMEOUT_EN
                end else if (busy_cnt == 32'(PR_TIMEOUT_CYCLES - 1)) begin
                    timeout_hit = 1'b1;
                    state_next  = PR_IDLE;
`endif
                end
            end
            default: state_next = PR_IDLE;
        endcase
    end

    // Latch the accepted head so slot/bitstream hold through BUSY and IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q      <= '0;
            bitstream_q <= '0;
        end else if (pop) begin
            slot_q      <= head.slot;
            bitstream_q <= head.bitstream;
        end
    end

`ifdef RCA_PR_TIMEOUT_EN
    // Watchdog: restarts on acceptance, counts each BUSY cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cnt <= '0;
        end else if (pop) begin
            busy_cnt <= '0;
        end else if (state == PR_BUSY) begin
            busy_cnt <= busy_cnt + 32'd1;
        end
    end

    // Sticky error; clear wins over a same-cycle timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pr_error <= 1'b0;
        end else if (pr_error_clr) begin
            pr_error <= 1'b0;
        end else if (timeout_hit) begin
            pr_error <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_rca_pr_scheduler.sv
// Randomized scoreboard bench for rca_pr_scheduler, with a queue-based reference model.
module tb_rca_pr_scheduler;
    import taiga_types::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TO    = 16;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      pr_req_valid;
    logic                      pr_req_ready;
    logic [SLOT_W-1:0]         pr_req_slot;
    logic [BITSTREAM_ID_W-1:0] pr_req_bitstream;
    logic                      rca_config_locked;
    logic                      pr_start;
    logic                      pr_start_ready;
    logic [SLOT_W-1:0]         pr_slot;
    logic [BITSTREAM_ID_W-1:0] pr_bitstream;
    logic                      pr_done;
    logic                      pr_requests_incomplete;
    logic [NUM_GRID_SLOTS-1:0] pr_slot_busy;
    logic                      pr_error;
    logic                      pr_error_clr;

    int unsigned compared   = 0;
    int unsigned mismatched = 0;

    rca_pr_scheduler #(
        .PR_QUEUE_DEPTH   (DEPTH),
        .PR_TIMEOUT_CYCLES(TO)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .pr_req_valid          (pr_req_valid),
        .pr_req_ready          (pr_req_ready),
        .pr_req_slot           (pr_req_slot),
        .pr_req_bitstream      (pr_req_bitstream),
        .rca_config_locked     (rca_config_locked),
        .pr_start              (pr_start),
        .pr_start_ready        (pr_start_ready),
        .pr_slot               (pr_slot),
        .pr_bitstream          (pr_bitstream),
        .pr_done               (pr_done),
        .pr_requests_incomplete(pr_requests_incomplete),
        .pr_slot_busy          (pr_slot_busy),
        .pr_error              (pr_error),
        .pr_error_clr          (pr_error_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending queue of accepted requests, plus issuing/active flags.
    rca_pr_req_t pending[$];
    rca_pr_req_t cur;
    bit          issuing;
    bit          active;
    bit          err;
    int unsigned busy_cycles;

    // Monitor: compares every output each cycle, scoreboards handshakes, then advances the model.
    always @(negedge clk) begin
        rca_pr_req_t r;
        bit          acc;
        bit          set_err;
        logic [SLOT_W-1:0]         exp_slot;
        logic [BITSTREAM_ID_W-1:0] exp_bs;
        if (rst) begin
            pending.delete();
            cur         = '0;
            issuing     = 0;
            active      = 0;
            err         = 0;
            busy_cycles = 0;
            check("rst_start", 32'(pr_start), 0);
            check("rst_slot", 32'(pr_slot), 0);
            check("rst_bitstream", 32'(pr_bitstream), 0);
            check("rst_slot_busy", 32'(pr_slot_busy), 0);
            check("rst_error", 32'(pr_error), 0);
            check("rst_ready", 32'(pr_req_ready), 1);
            check("rst_incomplete", 32'(pr_requests_incomplete), 0);
        end else begin
            exp_slot = issuing ? pending[0].slot : cur.slot;
            exp_bs   = issuing ? pending[0].bitstream : cur.bitstream;
            check("req_ready", 32'(pr_req_ready), 32'(pending.size() < DEPTH));
            check("start", 32'(pr_start), 32'(issuing));
            check("slot", 32'(pr_slot), 32'(exp_slot));
            check("bitstream", 32'(pr_bitstream), 32'(exp_bs));
            check("slot_busy", 32'(pr_slot_busy),
                  (issuing || active) ? (32'd1 << exp_slot) : 32'd0);
            check("incomplete", 32'(pr_requests_incomplete),
                  32'(pending.size() > 0 || issuing || active));
            check("error", 32'(pr_error), 32'(err));

            // Scoreboard: a DUT handshake must match the oldest accepted request.
            if (pr_start && pr_start_ready) begin
                if (pending.size() == 0) begin
                    check("issue_unexpected", 1, 0);
                end else begin
                    check("issue_slot", 32'(pr_slot), 32'(pending[0].slot));
                    check("issue_bitstream", 32'(pr_bitstream), 32'(pending[0].bitstream));
                end
            end

            // Advance model to the next edge using the values sampled now.
            acc     = pr_req_valid && (pending.size() < DEPTH);
            set_err = 0;
            if (issuing) begin
                if (pr_start_ready) begin
                    cur         = pending.pop_front();
                    issuing     = 0;
                    active      = 1;
                    busy_cycles = 0;
                end
            end else if (active) begin
                if (pr_done) begin
                    active = 0;
`ifdef RCA_PR_TIMEOUT_EN
                end else if (busy_cycles == TO - 1) begin
                    active  = 0;
                    set_err = 1;
                end else begin
                    busy_cycles++;
`endif
                end
            end else if (pending.size() > 0 && !rca_config_locked) begin
                issuing = 1;
            end
            if (acc) begin
                r.slot      = pr_req_slot;
                r.bitstream = pr_req_bitstream;
                pending.push_back(r);
            end
`ifdef RCA_PR_TIMEOUT_EN
            if (pr_error_clr) err = 0;
            else if (set_err) err = 1;
`endif
        end
    end

    // Drive one randomized cycle per clock; probabilities in percent.
    task automatic run(input int unsigned cycles, input int unsigned p_valid, input int unsigned p_lock,
                       input int unsigned p_sready, input int unsigned p_done, input int unsigned p_clr);
        for (int unsigned i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            pr_req_valid      = ($urandom_range(99) < p_valid);
            pr_req_slot       = SLOT_W'($urandom);
            pr_req_bitstream  = BITSTREAM_ID_W'($urandom);
            rca_config_locked = ($urandom_range(99) < p_lock);
            pr_start_ready    = ($urandom_range(99) < p_sready);
            pr_done           = ($urandom_range(99) < p_done);
            pr_error_clr      = ($urandom_range(99) < p_clr);
        end
    endtask

    // Stimulus sequence.
    initial begin
        rst               = 1'b1;
        pr_req_valid      = 1'b0;
        pr_req_slot       = '0;
        pr_req_bitstream  = '0;
        rca_config_locked = 1'b0;
        pr_start_ready    = 1'b0;
        pr_done           = 1'b0;
        pr_error_clr      = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        run(200, 30, 20, 70, 30, 5);   // mixed traffic
        run(25, 100, 100, 100, 0, 0);  // locked: fill to full, extra pushes dropped
        run(80, 0, 0, 100, 50, 0);     // unlock and drain in order
        run(10, 100, 0, 0, 0, 0);      // refill, then stall the handshake
        run(30, 0, 0, 0, 0, 0);
        run(60, 20, 0, 100, 0, 0);     // long BUSY with no done
        run(5, 0, 0, 0, 0, 100);       // clear any error
        run(15, 80, 0, 100, 0, 0);     // get BUSY with requests queued
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        run(300, 40, 30, 60, 25, 5);   // random soak
        run(150, 0, 0, 100, 40, 0);    // final drain
        @(negedge clk);
        check("drained", 32'(pr_requests_incomplete), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
